// File: rtl/smol_pkg.sv
// Shared types and constants for the SmolCore instruction encoder:
// format codes, encoder FSM states, base opcodes and an immediate fit helper.
package smol_pkg;

    typedef enum logic [2:0] {
        FMT_ILL0 = 3'b000,
        FMT_U    = 3'b001,
        FMT_I    = 3'b010,
        FMT_S    = 3'b011,
        FMT_R    = 3'b100,
        FMT_J    = 3'b101,
        FMT_B    = 3'b110,
        FMT_ILL7 = 3'b111
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_ERR  = 2'b10
    } enc_state_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // True when v[31:msb] are all equal, i.e. v is a sign extension of v[msb:0].
    function automatic logic sext_fits(input logic [31:0] v, input int unsigned msb);
        logic [31:0] s;
        s = 32'($signed(v) >>> msb);
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/smol_imm_pack.sv
// Combinational RV32I word packer with format and immediate range checks.
// Range checks exist only when SMOL_ENC_RANGE_CHECK_EN is defined.
module smol_imm_pack
    import smol_pkg::*;
(
    input  logic [2:0]  i_fmt,
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [31:0] i_imm,
    output logic [31:0] o_instr,
    output logic        o_range_err,
    output logic        o_fmt_err
);

    always_comb begin
        o_instr   = '0;
        o_fmt_err = 1'b0;
        case (fmt_e'(i_fmt))
            FMT_U: o_instr = {i_imm[31:12], i_rd, i_opcode};
            FMT_I: o_instr = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
            FMT_S: o_instr = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
            FMT_R: o_instr = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            FMT_J: o_instr = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
            FMT_B: o_instr = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                              i_imm[4:1], i_imm[11], i_opcode};
            default: o_fmt_err = 1'b1;
        endcase
    end

`ifdef SMOL_ENC_RANGE_CHECK_EN
    always_comb begin
        o_range_err = 1'b0;
        case (fmt_e'(i_fmt))
            FMT_U:        o_range_err = (i_imm[11:0] != '0);
            FMT_I, FMT_S: o_range_err = !sext_fits(i_imm, 11);
            FMT_J:        o_range_err = i_imm[0] || !sext_fits(i_imm, 20);
            FMT_B:        o_range_err = i_imm[0] || !sext_fits(i_imm, 12);
            default:      o_range_err = 1'b0;
        endcase
    end
`else
    assign o_range_err = 1'b0;
`endif

endmodule

// File: rtl/smol_ins_enc.sv
// SmolCore instruction encoder/program writer: accepts field bundles, emits packed
// words with sequential addresses. Optional range checking: SMOL_ENC_RANGE_CHECK_EN.
module smol_ins_enc
    import smol_pkg::*;
#(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_fmt,
    output logic              err_range,
    output logic              wrapped,
    output logic [1:0]        state_o
);

    enc_state_e        r_state;
    enc_state_e        w_state_next;
    logic              r_out_valid;
    logic [31:0]       r_out_instr;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err_fmt;
    logic              r_err_range;
    logic              r_wrapped;

    logic [31:0]       w_packed;
    logic              w_fmt_err;
    logic              w_range_err;
    logic              w_accept;
    logic              w_drain;
    logic              w_bad;

    smol_imm_pack u_pack (
        .i_fmt       (in_fmt),
        .i_opcode    (opcode),
        .i_rd        (rd),
        .i_rs1       (rs1),
        .i_rs2       (rs2),
        .i_funct3    (funct3),
        .i_funct7    (funct7),
        .i_imm       (imm),
        .o_instr     (w_packed),
        .o_range_err (w_range_err),
        .o_fmt_err   (w_fmt_err)
    );

    // clear wins over any handshake presented in the same cycle
    assign w_accept = in_valid && in_ready && !clear;
    assign w_drain  = r_out_valid && out_ready;
    assign w_bad    = w_fmt_err || w_range_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (start) w_state_next = ST_RUN;
                ST_RUN:  if (w_accept && w_bad) w_state_next = ST_ERR;
                ST_ERR:  w_state_next = ST_ERR;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = (r_state == ST_RUN) && (!r_out_valid || out_ready);
        state_o  = r_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_addr      <= BASE_ADDR;
            r_err_fmt   <= 1'b0;
            r_err_range <= 1'b0;
            r_wrapped   <= 1'b0;
        end else if (clear) begin
            r_out_valid <= 1'b0;
            r_addr      <= BASE_ADDR;
            r_err_fmt   <= 1'b0;
            r_err_range <= 1'b0;
            r_wrapped   <= 1'b0;
        end else begin
            if (w_drain) begin
                r_out_valid <= 1'b0;
                r_addr      <= r_addr + 1'b1;
                if (r_addr == '1) r_wrapped <= 1'b1;
            end
            if (w_accept) begin
                if (w_bad) begin
                    r_err_fmt   <= r_err_fmt   | w_fmt_err;
                    r_err_range <= r_err_range | w_range_err;
                end else begin
                    r_out_valid <= 1'b1;
                    r_out_instr <= w_packed;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_addr  = r_addr;
    assign err_fmt   = r_err_fmt;
    assign err_range = r_err_range;
    assign wrapped   = r_wrapped;

endmodule

// File: doc/smol_ins_enc.md
Name: smol_ins_enc

Overview:
- Instruction encoder and program writer for SmolCore. It is the packing end of the instruction-field interface that the core's decoder unpacks.
- Accepts a format code, the register/function fields and a 32-bit immediate over a valid/ready stream, then packs a legal RV32I instruction word.
- Emits the word with a sequential write address over a second valid/ready stream, typically into instruction memory or a test-program loader.
- Range-checks immediates and halts on errors until cleared.

Parameters:
- ADDR_W, 10, width of the word-address counter (out_addr).
- BASE_ADDR, 0, address loaded on reset and on clear. Width ADDR_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; moves IDLE to RUN.
- clear  in  1  synchronous; returns to IDLE, reloads address, clears sticky flags.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder can accept.
- in_fmt  in  3  format: 001 U, 010 I, 011 S, 100 R, 101 J, 110 B; 000 and 111 are illegal.
- opcode  in  7  placed in bits 6:0.
- rd, rs1, rs2  in  5 each  register fields.
- funct3  in  3; funct7  in  7  function fields.
- imm  in  32  immediate; byte-offset value for B and J, upper-aligned value for U.
- out_valid  out  1  word valid.
- out_ready  in  1  sink accepts.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  word address of out_instr.
- err_fmt  out  1  sticky; illegal format seen.
- err_range  out  1  sticky; immediate not representable.
- wrapped  out  1  sticky; address counter wrapped.
- state_o  out  2  current FSM state (debug).

Behaviour:
- Reset values: state IDLE, out_valid 0, out_instr 0, out_addr BASE_ADDR, all sticky flags 0, in_ready 0.
- FSM states (state_o encoding):
  - IDLE=00: in_ready=0. start goes to RUN.
  - RUN=01: in_ready = !out_valid || out_ready.
  - ERR=10: in_ready=0. Entered on an accepted input that has a format or range error. Only clear or rst leaves ERR.
- clear has priority over start and over an input handshake in the same cycle.
- An input is accepted on in_valid && in_ready.
- A legal accepted input produces registered out_instr and out_valid=1 on the next cycle. Latency is 1 cycle.
- An erroring input is dropped: no word is emitted, the matching flag is set, and the state goes to ERR.
- Output register:
  - Holds its value while out_valid && !out_ready.
  - Reloads in the same cycle it drains if a new input is accepted. Full throughput is 1 word per cycle.
- Address counter:
  - Increments by 1 on each out_valid && out_ready. out_addr is stable while the word is stalled.
  - Wraps from 2^ADDR_W-1 to 0 and sets wrapped.
- clear:
  - Drops any pending output word (out_valid goes to 0).
  - Sets out_addr to BASE_ADDR and clears all sticky flags.
- Packing:
  - R: funct7 | rs2 | rs1 | funct3 | rd | opcode.
  - I: imm[11:0] | rs1 | funct3 | rd | opcode.
  - S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode.
  - B: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | opcode.
  - U: imm[31:12] | rd | opcode.
  - J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | opcode.
  - Fields unused by a format are ignored.
- Range rules:
  - I and S: imm[31:11] all equal.
  - B: imm[0]=0 and imm[31:12] all equal.
  - J: imm[0]=0 and imm[31:20] all equal.
  - U: imm[11:0]=0.
  - R: no check.
- If both error types occur on one input, both flags are set.

Optional Feature:
- Macro: SMOL_ENC_RANGE_CHECK_EN.
- Defined: range rules are enforced as above.
- Undefined:
  - No range check is performed; immediates are silently truncated to the packing fields.
  - err_range is tied to 0.
  - Format errors still go to ERR.

Decomposition:
- Package smol_pkg holds:
  - typedef enum fmt_e for the 3-bit formats.
  - typedef enum enc_state_e for the FSM.
  - opcode localparams (OP_IMM, STORE, BRANCH, JAL, LUI, ...).
- One combinational sub-module, smol_imm_pack. Inputs: fmt and the fields. Outputs: the packed word plus range_err and fmt_err.
- The top-level holds the FSM, output register, address counter and sticky flags.

Test Plan:
- rst, start, then I fmt, opcode 0010011, rd=1, rs1=0, funct3=0, imm=5 -> next cycle out_valid=1, out_instr=0x00500093, out_addr=0.
- S fmt, opcode 0100011, funct3=010, rs1=1, rs2=2, imm=8, then B fmt, opcode 1100011, rs1=rs2=0, funct3=0, imm=-4 -> 0x0020A423 at addr 0, then 0xFE000EE3 at addr 1.
- J fmt, opcode 1101111, rd=1, imm=0x800 -> 0x001000EF. Same input with imm=0x801 -> err_range=1, no output word, state_o=10, in_ready=0.
- In ERR, pulse clear -> state IDLE, flags 0, out_addr=BASE_ADDR. in_fmt=111 in RUN -> err_fmt=1 and ERR.
- Hold out_ready=0 for 3 cycles with two inputs queued -> first word held stable, in_ready=0, second input stalls. Release -> words appear at addrs 0 and 1 with no loss or duplication.
- ADDR_W=2, emit 5 words -> out_addr sequence 0,1,2,3,0, and wrapped=1 after the fifth handshake.
